// File: rtl/msk_pkg.sv
// Shared definitions for the MSK transmit path: framer state type, default
// framing constants and the samples-per-bit default used by the modem models.
package msk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_TAIL     = 3'd4
    } tx_state_e;

    localparam int         SPB_DEFAULT          = 20;
    localparam logic [7:0] PREAMBLE_PAT_DEFAULT = 8'hAA;
    localparam logic [15:0] SYNC_WORD_DEFAULT   = 16'h1ACF;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/msk_bit_timer.sv
// Sample counter for the serial bit stream: restarts at the first clock of a
// frame, marks the first clock of each bit and flags the last and next-to-last samples.
module msk_bit_timer
    import msk_pkg::*;
#(
    parameter int SPB = SPB_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic bit_strobe,
    output logic last_sample,
    output logic pre_last
);

    localparam int             CW       = $clog2(SPB);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SPB - 1);
    localparam logic [CW-1:0]  CNT_PRE  = CW'(SPB - 2);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic          run_r;

    // Next sample index: zero while idle and on the first clock of a frame.
    always_comb begin
        cnt_nx_s = '0;
        if (!en || !run_r) begin
            cnt_nx_s = '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_nx_s = '0;
        end else begin
            cnt_nx_s = cnt_r + CW'(1);
        end
    end

    // Sample counter, run flag and registered bit strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r      <= '0;
            run_r      <= 1'b0;
            bit_strobe <= 1'b0;
        end else begin
            cnt_r      <= cnt_nx_s;
            run_r      <= en;
            bit_strobe <= en && (cnt_nx_s == '0);
        end
    end

    assign last_sample = run_r && (cnt_r == CNT_LAST);
    assign pre_last    = run_r && (cnt_r == CNT_PRE);

endmodule

// File: rtl/msk_tx_framer.sv
// Byte-stream to serial-bit framer feeding the MSK modulator: preamble, sync
// word, payload bytes MSB first and a zero tail, each bit held SPB clocks.
module msk_tx_framer
    import msk_pkg::*;
#(
    parameter int          SPB            = SPB_DEFAULT,
    parameter int          PREAMBLE_BYTES = 4,
    parameter logic [7:0]  PREAMBLE_PAT   = PREAMBLE_PAT_DEFAULT,
    parameter logic [15:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
    parameter int          TAIL_BITS      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic       bit_out,
    output logic       bit_strobe,
    output logic       tx_active,
    output logic       underrun
);

    localparam int             BCW       = $clog2(max3(PREAMBLE_BYTES * 8, 16, TAIL_BITS));
    localparam logic [BCW-1:0] PRE_LAST  = BCW'(PREAMBLE_BYTES * 8 - 1);
    localparam logic [BCW-1:0] SYNC_LAST = BCW'(15);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(7);
    localparam logic [BCW-1:0] TAIL_LAST = BCW'(TAIL_BITS - 1);

    tx_state_e      state_r, state_nx_s;
    logic [BCW-1:0] bit_cnt_r, bit_cnt_nx_s, bit_cnt_inc_s;
    logic [7:0]     shift_r, shift_nx_s;
    logic           last_r, last_nx_s;
    logic           bit_out_nx_s, active_nx_s, underrun_nx_s, tready_nx_s;
    logic           last_sample_s, pre_last_s;

    msk_bit_timer #(.SPB(SPB)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .en          (active_nx_s),
        .bit_strobe  (bit_strobe),
        .last_sample (last_sample_s),
        .pre_last    (pre_last_s)
    );

    assign bit_cnt_inc_s = bit_cnt_r + BCW'(1);

    // s_tready is registered, so it is raised one clock ahead of each fetch point.
    always_comb begin
        tready_nx_s = 1'b0;
        if (pre_last_s) begin
            tready_nx_s = ((state_r == ST_SYNC) && (bit_cnt_r == SYNC_LAST)) ||
                          ((state_r == ST_PAYLOAD) && (bit_cnt_r == BYTE_LAST) && !last_r);
        end else begin
            tready_nx_s = 1'b0;
        end
    end

    // Framer next state; a fetch point either loads a byte or aborts the frame.
    always_comb begin
        state_nx_s    = state_r;
        bit_cnt_nx_s  = bit_cnt_r;
        shift_nx_s    = shift_r;
        last_nx_s     = last_r;
        bit_out_nx_s  = bit_out;
        active_nx_s   = tx_active;
        underrun_nx_s = 1'b0;
        if (s_tready) begin
            bit_cnt_nx_s = '0;
            if (s_tvalid) begin
                state_nx_s   = ST_PAYLOAD;
                shift_nx_s   = s_tdata;
                last_nx_s    = s_tlast;
                bit_out_nx_s = s_tdata[7];
            end else begin
                state_nx_s    = ST_IDLE;
                underrun_nx_s = 1'b1;
                bit_out_nx_s  = 1'b0;
                active_nx_s   = 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (s_tvalid) begin
                        state_nx_s   = ST_PREAMBLE;
                        bit_cnt_nx_s = '0;
                        bit_out_nx_s = PREAMBLE_PAT[7];
                        active_nx_s  = 1'b1;
                    end else begin
                        bit_out_nx_s = 1'b0;
                        active_nx_s  = 1'b0;
                    end
                end
                ST_PREAMBLE: begin
                    if (!last_sample_s) begin
                        bit_cnt_nx_s = bit_cnt_r;
                    end else if (bit_cnt_r == PRE_LAST) begin
                        state_nx_s   = ST_SYNC;
                        bit_cnt_nx_s = '0;
                        bit_out_nx_s = SYNC_WORD[15];
                    end else begin
                        bit_cnt_nx_s = bit_cnt_inc_s;
                        bit_out_nx_s = PREAMBLE_PAT[~bit_cnt_inc_s[2:0]];
                    end
                end
                ST_SYNC: begin
                    // The final sync bit always ends at a fetch point; this is only a safe exit.
                    if (!last_sample_s) begin
                        bit_cnt_nx_s = bit_cnt_r;
                    end else if (bit_cnt_r == SYNC_LAST) begin
                        state_nx_s   = ST_IDLE;
                        bit_cnt_nx_s = '0;
                        bit_out_nx_s = 1'b0;
                        active_nx_s  = 1'b0;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_inc_s;
                        bit_out_nx_s = SYNC_WORD[~bit_cnt_inc_s[3:0]];
                    end
                end
                ST_PAYLOAD: begin
                    if (!last_sample_s) begin
                        bit_cnt_nx_s = bit_cnt_r;
                    end else if (bit_cnt_r == BYTE_LAST) begin
                        state_nx_s   = ST_TAIL;
                        bit_cnt_nx_s = '0;
                        bit_out_nx_s = 1'b0;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_inc_s;
                        shift_nx_s   = {shift_r[6:0], 1'b0};
                        bit_out_nx_s = shift_r[6];
                    end
                end
                ST_TAIL: begin
                    if (!last_sample_s) begin
                        bit_cnt_nx_s = bit_cnt_r;
                    end else if (bit_cnt_r == TAIL_LAST) begin
                        state_nx_s   = ST_IDLE;
                        bit_cnt_nx_s = '0;
                        bit_out_nx_s = 1'b0;
                        active_nx_s  = 1'b0;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_inc_s;
                        bit_out_nx_s = 1'b0;
                    end
                end
                default: begin
                    state_nx_s   = ST_IDLE;
                    bit_cnt_nx_s = '0;
                    bit_out_nx_s = 1'b0;
                    active_nx_s  = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= '0;
            shift_r   <= 8'h00;
            last_r    <= 1'b0;
            bit_out   <= 1'b0;
            tx_active <= 1'b0;
            underrun  <= 1'b0;
            s_tready  <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            shift_r   <= shift_nx_s;
            last_r    <= last_nx_s;
            bit_out   <= bit_out_nx_s;
            tx_active <= active_nx_s;
            underrun  <= underrun_nx_s;
            s_tready  <= tready_nx_s;
        end
    end

endmodule

// File: tb/tb_msk_tx_framer.sv
// Directed bench for msk_tx_framer: default-parameter instance plus a short
// SPB=4, one-preamble-byte instance, checked against hand-computed frames.
module tb_msk_tx_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tlast;
    logic       s_tready, bit_out, bit_strobe, tx_active, underrun;
    logic [7:0] d4_tdata;
    logic       d4_tvalid, d4_tlast;
    logic       d4_tready, d4_bit_out, d4_bit_strobe, d4_tx_active, d4_underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    msk_tx_framer dut (
        .clk(clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .bit_out(bit_out),
        .bit_strobe(bit_strobe), .tx_active(tx_active), .underrun(underrun)
    );

    msk_tx_framer #(.SPB(4), .PREAMBLE_BYTES(1)) dut4 (
        .clk(clk), .reset(reset), .s_tdata(d4_tdata), .s_tvalid(d4_tvalid),
        .s_tlast(d4_tlast), .s_tready(d4_tready), .bit_out(d4_bit_out),
        .bit_strobe(d4_bit_strobe), .tx_active(d4_tx_active), .underrun(d4_underrun)
    );

    // Monitor of the default instance, sampled on the falling edge.
    logic bit_q[$];
    int   ready_q[$], rise_q[$], fall_q[$], und_q[$];
    logic act_p = 1'b0, bit_p = 1'b0;
    logic [1:0] und_st = 2'b11;
    int   viol = 0;

    always @(negedge clk) begin
        if (reset) begin
            act_p <= 1'b0;
            bit_p <= 1'b0;
        end else begin
            if (bit_strobe) bit_q.push_back(bit_out);
            if (s_tready) ready_q.push_back(cyc);
            if (underrun) begin
                und_q.push_back(cyc);
                und_st <= {tx_active, bit_out};
            end
            if (tx_active && !act_p) rise_q.push_back(cyc);
            if (!tx_active && act_p) fall_q.push_back(cyc);
            if (tx_active && (bit_out !== bit_p) && !bit_strobe) viol <= viol + 1;
            act_p <= tx_active;
            bit_p <= bit_out;
        end
    end

    // Monitor of the SPB=4 instance.
    logic bit4_q[$];
    int   strobe4_q[$], ready4_q[$], rise4_q[$], fall4_q[$];
    logic act4_p = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            act4_p <= 1'b0;
        end else begin
            if (d4_bit_strobe) begin
                bit4_q.push_back(d4_bit_out);
                strobe4_q.push_back(cyc);
            end
            if (d4_tready) ready4_q.push_back(cyc);
            if (d4_tx_active && !act4_p) rise4_q.push_back(cyc);
            if (!d4_tx_active && act4_p) fall4_q.push_back(cyc);
            act4_p <= d4_tx_active;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] seg(input logic q[$], input int start, input int len);
        logic [63:0] v = 64'h0;
        for (int i = 0; i < len; i++) v = {v[62:0], q[start + i]};
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic last, input string tag);
        logic seen = 1'b0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = s_tready;
        end
        check(tag, {63'h0, seen}, 64'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(input int n, input string tag);
        for (int i = 0; i < 4000 && fall_q.size() < n; i++) @(negedge clk);
        check(tag, {63'h0, fall_q.size() >= n}, 64'h1);
    endtask

    int b0, r0, f0, q0, u0, st, gap_err;
    logic seen4;

    initial begin
        reset = 1'b1;
        s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0;
        d4_tdata = 8'h00; d4_tvalid = 1'b0; d4_tlast = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {59'h0, bit_out, bit_strobe, s_tready, tx_active, underrun}, 64'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5
        b0 = bit_q.size(); r0 = rise_q.size(); f0 = fall_q.size(); q0 = ready_q.size();
        st = cyc;
        send_byte(8'hA5, 1'b1, "t1_ready");
        s_tvalid = 1'b0;
        wait_fall(f0 + 1, "t1_done");
        check("t1_start_lat", rise_q[r0] - st, 64'd1);
        check("t1_len", fall_q[f0] - rise_q[r0], 64'd1280);
        check("t1_nbits", bit_q.size() - b0, 64'd64);
        check("t1_preamble", seg(bit_q, b0, 32), 64'hAAAAAAAA);
        check("t1_sync", seg(bit_q, b0 + 32, 16), 64'h1ACF);
        check("t1_payload", seg(bit_q, b0 + 48, 8), 64'hA5);
        check("t1_tail", seg(bit_q, b0 + 56, 8), 64'h00);
        check("t1_nready", ready_q.size() - q0, 64'd1);
        check("t1_ready_off", ready_q[q0] - rise_q[r0], 64'd959);
        repeat (3) @(negedge clk);

        // Four bytes, s_tvalid held high
        b0 = bit_q.size(); r0 = rise_q.size(); f0 = fall_q.size(); q0 = ready_q.size();
        send_byte(8'h10, 1'b0, "t2_ready0");
        send_byte(8'h33, 1'b0, "t2_ready1");
        send_byte(8'hFF, 1'b0, "t2_ready2");
        send_byte(8'h1A, 1'b1, "t2_ready3");
        s_tvalid = 1'b0;
        wait_fall(f0 + 1, "t2_done");
        check("t2_nready", ready_q.size() - q0, 64'd4);
        for (int i = 1; i < 4; i++)
            check($sformatf("t2_gap%0d", i), ready_q[q0 + i] - ready_q[q0 + i - 1], 64'd160);
        check("t2_payload", seg(bit_q, b0 + 48, 32), 64'h1033FF1A);
        check("t2_tail", seg(bit_q, b0 + 80, 8), 64'h00);
        check("t2_len", fall_q[f0] - rise_q[r0], 64'd1760);
        repeat (3) @(negedge clk);

        // Underrun at the second fetch point
        b0 = bit_q.size(); f0 = fall_q.size(); q0 = ready_q.size(); u0 = und_q.size();
        send_byte(8'h5C, 1'b0, "t3_ready");
        s_tvalid = 1'b0;
        wait_fall(f0 + 1, "t3_done");
        check("t3_nready", ready_q.size() - q0, 64'd2);
        check("t3_nunder", und_q.size() - u0, 64'd1);
        check("t3_under_time", und_q[u0] - ready_q[q0 + 1], 64'd1);
        check("t3_after_under", {62'h0, und_st}, 64'h0);
        check("t3_fall_time", fall_q[f0] - und_q[u0], 64'd0);
        check("t3_nbits", bit_q.size() - b0, 64'd56);
        check("t3_payload", seg(bit_q, b0 + 48, 8), 64'h5C);
        repeat (3) @(negedge clk);

        // Reset in the middle of the payload
        u0 = und_q.size();
        send_byte(8'hC3, 1'b0, "t4_ready");
        s_tdata = 8'h77; s_tlast = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_midframe_active", {63'h0, tx_active}, 64'h1);
        #2 reset = 1'b1;
        #1 check("t4_async_reset", {60'h0, bit_out, bit_strobe, s_tready, tx_active}, 64'h0);
        s_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_no_underrun", und_q.size() - u0, 64'd0);
        b0 = bit_q.size(); r0 = rise_q.size(); f0 = fall_q.size();
        send_byte(8'h3C, 1'b1, "t4_ready_fresh");
        s_tvalid = 1'b0;
        wait_fall(f0 + 1, "t4_done");
        check("t4_preamble", seg(bit_q, b0, 32), 64'hAAAAAAAA);
        check("t4_sync_payload", seg(bit_q, b0 + 32, 24), 64'h1ACF3C);
        check("t4_len", fall_q[f0] - rise_q[r0], 64'd1280);
        repeat (3) @(negedge clk);

        // Back-to-back frames
        b0 = bit_q.size(); r0 = rise_q.size(); f0 = fall_q.size();
        send_byte(8'h81, 1'b1, "t5_ready1");
        s_tdata = 8'h42; s_tlast = 1'b1;
        send_byte(8'h42, 1'b1, "t5_ready2");
        s_tvalid = 1'b0;
        wait_fall(f0 + 2, "t5_done");
        check("t5_idle_gap", rise_q[r0 + 1] - fall_q[f0], 64'd1);
        check("t5_len1", fall_q[f0] - rise_q[r0], 64'd1280);
        check("t5_len2", fall_q[f0 + 1] - rise_q[r0 + 1], 64'd1280);
        check("t5_payload1", seg(bit_q, b0 + 48, 8), 64'h81);
        check("t5_frame2", seg(bit_q, b0 + 64 + 32, 24), 64'h1ACF42);

        // SPB=4, one preamble byte, payload 0x00
        @(negedge clk);
        d4_tdata = 8'h00; d4_tlast = 1'b1; d4_tvalid = 1'b1;
        seen4 = 1'b0;
        for (int i = 0; i < 500 && !seen4; i++) begin
            @(negedge clk);
            seen4 = d4_tready;
        end
        check("t6_ready", {63'h0, seen4}, 64'h1);
        @(posedge clk);
        #1 d4_tvalid = 1'b0;
        for (int i = 0; i < 500 && fall4_q.size() < 1; i++) @(negedge clk);
        check("t6_done", fall4_q.size(), 64'd1);
        check("t6_len", fall4_q[0] - rise4_q[0], 64'd160);
        check("t6_nstrobe", strobe4_q.size(), 64'd40);
        gap_err = 0;
        for (int i = 1; i < strobe4_q.size(); i++)
            if (strobe4_q[i] - strobe4_q[i - 1] != 4) gap_err++;
        check("t6_strobe_gap", gap_err, 64'd0);
        check("t6_first_strobe", strobe4_q[0] - rise4_q[0], 64'd0);
        check("t6_bits", seg(bit4_q, 0, 40), 64'hAA1ACF0000);
        check("t6_ready_off", ready4_q[0] - rise4_q[0], 64'd95);

        check("bit_change_off_strobe", viol, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
